dmem_bridge: RTL and testbench

//  Data-memory bridge between the multicycle RV32I core's MEMORY-stage outputs and the data RAM bus.

---
 rtl/dmem_pkg.sv | 34 +++
 rtl/dmem_bridge_if.sv | 30 +++
 rtl/dmem_lane_align.sv | 56 +++++
 rtl/dmem_bridge.sv | 144 ++++++++++++++
 tb/tb_dmem_bridge.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory bridge: access sizes, FSM encoding
// and the request legality check.
package dmem_pkg;

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // Unsigned sizes only make sense for loads, so a store using them is illegal.
    function automatic logic access_reject(input logic [2:0] size,
                                           input logic [1:0] off,
                                           input logic       is_store);
        logic bad;
        bad = 1'b0;
        case (size)
            SZ_B:    bad = 1'b0;
            SZ_H:    bad = off[0];
            SZ_W:    bad = (off != 2'b00);
            SZ_BU:   bad = is_store;
            SZ_HU:   bad = is_store | off[0];
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_bridge_if.sv
// Core-side request/response and RAM-side req/ack bus of the data-memory bridge.
// The slave modport is the bridge; the master modport is the core plus RAM.
interface dmem_bridge_if;
    logic        MemRead;
    logic        MemWrite;
    logic [2:0]  funct3;
    logic [31:0] dAddress;
    logic [31:0] dWriteData;
    logic [31:0] dReadData;
    logic        dValid;
    logic        dErr;
    logic        dBusy;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport slave (
        input  MemRead, MemWrite, funct3, dAddress, dWriteData, bus_ack, bus_rdata,
        output dReadData, dValid, dErr, dBusy, bus_req, bus_we, bus_addr, bus_be, bus_wdata
    );

    modport master (
        output MemRead, MemWrite, funct3, dAddress, dWriteData, bus_ack, bus_rdata,
        input  dReadData, dValid, dErr, dBusy, bus_req, bus_we, bus_addr, bus_be, bus_wdata
    );
endinterface

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane logic: store byte enables / data replication and
// load lane selection with sign or zero extension.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]  st_size_i,
    input  logic [1:0]  st_off_i,
    input  logic [31:0] st_data_i,
    output logic [3:0]  st_be_o,
    output logic [31:0] st_wdata_o,
    input  logic [2:0]  ld_size_i,
    input  logic [1:0]  ld_off_i,
    input  logic [31:0] ld_word_i,
    output logic [31:0] ld_data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        st_be_o    = 4'b0001 << st_off_i;
        st_wdata_o = {4{st_data_i[7:0]}};
        case (st_size_i)
            SZ_H: begin
                st_be_o    = 4'b0011 << st_off_i;
                st_wdata_o = {2{st_data_i[15:0]}};
            end
            SZ_W: begin
                st_be_o    = 4'hF;
                st_wdata_o = st_data_i;
            end
            default: ;
        endcase
    end

    always_comb begin
        byte_sel = ld_word_i[7:0];
        case (ld_off_i)
            2'd1:    byte_sel = ld_word_i[15:8];
            2'd2:    byte_sel = ld_word_i[23:16];
            2'd3:    byte_sel = ld_word_i[31:24];
            default: byte_sel = ld_word_i[7:0];
        endcase
        half_sel = ld_off_i[1] ? ld_word_i[31:16] : ld_word_i[15:0];

        ld_data_o = ld_word_i;
        case (ld_size_i)
            SZ_B:    ld_data_o = {{24{byte_sel[7]}}, byte_sel};
            SZ_BU:   ld_data_o = {24'd0, byte_sel};
            SZ_H:    ld_data_o = {{16{half_sel[15]}}, half_sel};
            SZ_HU:   ld_data_o = {16'd0, half_sel};
            default: ld_data_o = ld_word_i;
        endcase
    end

endmodule

// File: rtl/dmem_bridge.sv
// Data-memory bridge between the core MEMORY stage and the data RAM req/ack bus.
// Optional DMEM_TIMEOUT_EN aborts a BUSY access after TIMEOUT_CYCLES without ack.
//
// state | meaning
// IDLE  | waiting for MemRead^MemWrite; rejected requests jump straight to DONE
// BUSY  | bus_req held with stable bus outputs until bus_ack (or timeout)
// DONE  | one-cycle dValid (with dErr if rejected), dBusy still high
module dmem_bridge
    import dmem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input logic           clk,
    input logic           rst,
    dmem_bridge_if.slave  dif
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 256) begin : g_tmo_range
        $error("TIMEOUT_CYCLES must fit the 8-bit timeout counter");
    end

    state_e      state_q;
    logic [31:0] dReadData_q;
    logic        dValid_q;
    logic        dErr_q;
    logic        dBusy_q;
    logic        bus_req_q;
    logic        bus_we_q;
    logic [31:0] bus_addr_q;
    logic [3:0]  bus_be_q;
    logic [31:0] bus_wdata_q;
    logic [2:0]  size_q;
    logic [1:0]  off_q;

    logic [3:0]  st_be;
    logic [31:0] st_wdata;
    logic [31:0] ld_data;
    logic        req_any;
    logic        req_bad;

`ifdef DMEM_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] tmo_q;
`endif

    dmem_lane_align u_align (
        .st_size_i  (dif.funct3),
        .st_off_i   (dif.dAddress[1:0]),
        .st_data_i  (dif.dWriteData),
        .st_be_o    (st_be),
        .st_wdata_o (st_wdata),
        .ld_size_i  (size_q),
        .ld_off_i   (off_q),
        .ld_word_i  (dif.bus_rdata),
        .ld_data_o  (ld_data)
    );

    assign req_any = dif.MemRead | dif.MemWrite;
    assign req_bad = (dif.MemRead & dif.MemWrite)
                   | access_reject(dif.funct3, dif.dAddress[1:0], dif.MemWrite);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            dReadData_q <= '0;
            dValid_q    <= 1'b0;
            dErr_q      <= 1'b0;
            dBusy_q     <= 1'b0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_be_q    <= '0;
            bus_wdata_q <= '0;
            size_q      <= '0;
            off_q       <= '0;
`ifdef DMEM_TIMEOUT_EN
            tmo_q       <= '0;
`endif
        end else begin
            dValid_q <= 1'b0;
            dErr_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_any) begin
                        dBusy_q <= 1'b1;
                        if (req_bad) begin
                            state_q  <= DONE;
                            dValid_q <= 1'b1;
                            dErr_q   <= 1'b1;
                        end else begin
                            state_q     <= BUSY;
                            bus_req_q   <= 1'b1;
                            bus_we_q    <= dif.MemWrite;
                            bus_addr_q  <= {dif.dAddress[31:2], 2'b00};
                            bus_be_q    <= dif.MemWrite ? st_be : 4'hF;
                            bus_wdata_q <= dif.MemWrite ? st_wdata : 32'd0;
                            size_q      <= dif.funct3;
                            off_q       <= dif.dAddress[1:0];
`ifdef DMEM_TIMEOUT_EN
                            tmo_q       <= '0;
`endif
                        end
                    end
                end
                BUSY: begin
                    if (dif.bus_ack) begin
                        state_q   <= DONE;
                        bus_req_q <= 1'b0;
                        dValid_q  <= 1'b1;
                        if (!bus_we_q) begin
                            dReadData_q <= ld_data;
                        end
                    end
`ifdef DMEM_TIMEOUT_EN
                    else if (tmo_q == TMO_LAST) begin
                        state_q   <= DONE;
                        bus_req_q <= 1'b0;
                        dValid_q  <= 1'b1;
                        dErr_q    <= 1'b1;
                    end else begin
                        tmo_q <= tmo_q + 8'd1;
                    end
`endif
                end
                DONE: begin
                    state_q <= IDLE;
                    dBusy_q <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dif.dReadData = dReadData_q;
    assign dif.dValid    = dValid_q;
    assign dif.dErr      = dErr_q;
    assign dif.dBusy     = dBusy_q;
    assign dif.bus_req   = bus_req_q;
    assign dif.bus_we    = bus_we_q;
    assign dif.bus_addr  = bus_addr_q;
    assign dif.bus_be    = bus_be_q;
    assign dif.bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_dmem_bridge.sv
// Directed self-checking bench for dmem_bridge; the timeout scenario follows
// DMEM_TIMEOUT_EN so the bench matches whichever build is compiled.
module tb_dmem_bridge;

    localparam logic [2:0] F_B  = 3'b000;
    localparam logic [2:0] F_H  = 3'b001;
    localparam logic [2:0] F_W  = 3'b010;
    localparam logic [2:0] F_BU = 3'b100;
    localparam logic [2:0] F_HU = 3'b101;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    dmem_bridge_if dif ();

    dmem_bridge #(.TIMEOUT_CYCLES(16)) dut (
        .clk (clk),
        .rst (rst_n),
        .dif (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [104:0] all_outs();
        return {dif.dReadData, dif.dValid, dif.dErr, dif.dBusy, dif.bus_req,
                dif.bus_we, dif.bus_addr, dif.bus_be, dif.bus_wdata};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents a request for exactly one capture edge; returns in cycle 1.
    task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d);
        dif.MemRead    = rd;
        dif.MemWrite   = wr;
        dif.funct3     = f3;
        dif.dAddress   = a;
        dif.dWriteData = d;
        step();
        dif.MemRead  = 1'b0;
        dif.MemWrite = 1'b0;
    endtask

    task automatic test_reset();
        rst_n          = 1'b0;
        dif.MemRead    = 1'b0;
        dif.MemWrite   = 1'b0;
        dif.funct3     = 3'b000;
        dif.dAddress   = 32'd0;
        dif.dWriteData = 32'd0;
        dif.bus_ack    = 1'b0;
        dif.bus_rdata  = 32'd0;
        #2;
        n_cmp++; if (all_outs() !== 105'd0) begin n_bad++; $display("FAIL reset_outs: got %h want 0", all_outs()); end
        #10 rst_n = 1'b1;
        step();
        n_cmp++; if (all_outs() !== 105'd0) begin n_bad++; $display("FAIL reset_idle_outs: got %h want 0", all_outs()); end
        n_cmp++; if (dut.state_q !== 2'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", dut.state_q); end
    endtask

    task automatic test_lw();
        issue(1'b1, 1'b0, F_W, 32'h1001_0004, 32'd0);
        n_cmp++; if (dif.bus_req !== 1'b1) begin n_bad++; $display("FAIL lw_req_c1: got %b want 1", dif.bus_req); end
        n_cmp++; if (dif.bus_addr !== 32'h1001_0004) begin n_bad++; $display("FAIL lw_addr: got %h want 10010004", dif.bus_addr); end
        n_cmp++; if (dif.bus_be !== 4'hF) begin n_bad++; $display("FAIL lw_be: got %h want f", dif.bus_be); end
        n_cmp++; if (dif.bus_we !== 1'b0) begin n_bad++; $display("FAIL lw_we: got %b want 0", dif.bus_we); end
        n_cmp++; if (dif.dBusy !== 1'b1) begin n_bad++; $display("FAIL lw_busy_c1: got %b want 1", dif.dBusy); end
        step();
        n_cmp++; if ({dif.bus_req, dif.dValid} !== 2'b10) begin n_bad++; $display("FAIL lw_c2: got req,valid=%b want 10", {dif.bus_req, dif.dValid}); end
        dif.bus_ack   = 1'b1;
        dif.bus_rdata = 32'hDEAD_BEEF;
        step();
        dif.bus_ack = 1'b0;
        n_cmp++; if ({dif.dValid, dif.dErr, dif.dBusy, dif.bus_req} !== 4'b1010) begin n_bad++; $display("FAIL lw_c3: got valid,err,busy,req=%b want 1010", {dif.dValid, dif.dErr, dif.dBusy, dif.bus_req}); end
        n_cmp++; if (dif.dReadData !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL lw_data: got %h want deadbeef", dif.dReadData); end
        step();
        n_cmp++; if ({dif.dValid, dif.dBusy} !== 2'b00) begin n_bad++; $display("FAIL lw_c4: got valid,busy=%b want 00", {dif.dValid, dif.dBusy}); end
    endtask

    task automatic test_store();
        logic [31:0] addr_v [3];
        logic [2:0]  f3_v   [3];
        logic [31:0] d_v    [3];
        logic [3:0]  be_e   [3];
        logic [31:0] wd_e   [3];
        addr_v = '{32'h1001_0003, 32'h1001_0002, 32'h1001_0008};
        f3_v   = '{F_B, F_H, F_W};
        d_v    = '{32'h0000_00A5, 32'h1234_BEEF, 32'hCAFE_0123};
        be_e   = '{4'b1000, 4'b1100, 4'b1111};
        wd_e   = '{32'hA5A5_A5A5, 32'hBEEF_BEEF, 32'hCAFE_0123};
        for (int i = 0; i < 3; i++) begin
            issue(1'b0, 1'b1, f3_v[i], addr_v[i], d_v[i]);
            n_cmp++; if ({dif.bus_req, dif.bus_we} !== 2'b11) begin n_bad++; $display("FAIL st%0d_req_we: got %b want 11", i, {dif.bus_req, dif.bus_we}); end
            n_cmp++; if (dif.bus_be !== be_e[i]) begin n_bad++; $display("FAIL st%0d_be: got %b want %b", i, dif.bus_be, be_e[i]); end
            n_cmp++; if (dif.bus_wdata !== wd_e[i]) begin n_bad++; $display("FAIL st%0d_wdata: got %h want %h", i, dif.bus_wdata, wd_e[i]); end
            n_cmp++; if (dif.bus_addr !== {addr_v[i][31:2], 2'b00}) begin n_bad++; $display("FAIL st%0d_addr: got %h want %h", i, dif.bus_addr, {addr_v[i][31:2], 2'b00}); end
            dif.bus_ack = 1'b1;
            step();
            dif.bus_ack = 1'b0;
            n_cmp++; if ({dif.dValid, dif.dErr} !== 2'b10) begin n_bad++; $display("FAIL st%0d_done: got valid,err=%b want 10", i, {dif.dValid, dif.dErr}); end
            n_cmp++; if (dif.dReadData !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL st%0d_rdata_hold: got %h want deadbeef", i, dif.dReadData); end
            step();
        end
    endtask

    task automatic test_load_extend();
        logic [2:0]  f3_v [5];
        logic [31:0] a_v  [5];
        logic [31:0] rd_v [5];
        logic [31:0] exp  [5];
        f3_v = '{F_B, F_BU, F_H, F_HU, F_B};
        a_v  = '{32'h1001_0002, 32'h1001_0002, 32'h1001_0002, 32'h1001_0002, 32'h1001_0000};
        rd_v = '{32'h0080_0000, 32'h0080_0000, 32'h8001_0000, 32'h8001_0000, 32'h1234_567F};
        exp  = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001, 32'h0000_8001, 32'h0000_007F};
        for (int i = 0; i < 5; i++) begin
            issue(1'b1, 1'b0, f3_v[i], a_v[i], 32'd0);
            dif.bus_ack   = 1'b1;
            dif.bus_rdata = rd_v[i];
            step();
            dif.bus_ack = 1'b0;
            n_cmp++; if ({dif.dValid, dif.dErr} !== 2'b10) begin n_bad++; $display("FAIL ld%0d_done: got valid,err=%b want 10", i, {dif.dValid, dif.dErr}); end
            n_cmp++; if (dif.dReadData !== exp[i]) begin n_bad++; $display("FAIL ld%0d_data: got %h want %h", i, dif.dReadData, exp[i]); end
            step();
        end
    endtask

    task automatic test_reject();
        logic       rd_v [5];
        logic       wr_v [5];
        logic [2:0] f3_v [5];
        logic [31:0] a_v [5];
        rd_v = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        wr_v = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        f3_v = '{F_W, F_H, 3'b011, F_BU, F_W};
        a_v  = '{32'h1001_0002, 32'h1001_0001, 32'h1001_0000, 32'h1001_0000, 32'h1001_0000};
        for (int i = 0; i < 5; i++) begin
            issue(rd_v[i], wr_v[i], f3_v[i], a_v[i], 32'hFFFF_FFFF);
            n_cmp++; if ({dif.dValid, dif.dErr, dif.dBusy, dif.bus_req} !== 4'b1110) begin n_bad++; $display("FAIL rej%0d_c1: got valid,err,busy,req=%b want 1110", i, {dif.dValid, dif.dErr, dif.dBusy, dif.bus_req}); end
            n_cmp++; if (dif.dReadData !== 32'h0000_007F) begin n_bad++; $display("FAIL rej%0d_hold: got %h want 0000007f", i, dif.dReadData); end
            step();
            n_cmp++; if ({dif.dValid, dif.dErr, dif.dBusy, dif.bus_req} !== 4'b0000) begin n_bad++; $display("FAIL rej%0d_c2: got valid,err,busy,req=%b want 0000", i, {dif.dValid, dif.dErr, dif.dBusy, dif.bus_req}); end
        end
    endtask

    task automatic test_back_to_back();
        issue(1'b1, 1'b0, F_W, 32'h1001_0008, 32'd0);
        dif.MemWrite = 1'b1;
        dif.funct3   = F_W;
        dif.dAddress = 32'h2000_0000;
        n_cmp++; if (dif.bus_addr !== 32'h1001_0008) begin n_bad++; $display("FAIL bb_addr_c1: got %h want 10010008", dif.bus_addr); end
        step();
        n_cmp++; if ({dif.bus_req, dif.bus_we, dif.dValid} !== 3'b100) begin n_bad++; $display("FAIL bb_wait: got req,we,valid=%b want 100", {dif.bus_req, dif.bus_we, dif.dValid}); end
        n_cmp++; if (dif.bus_addr !== 32'h1001_0008) begin n_bad++; $display("FAIL bb_addr_c2: got %h want 10010008", dif.bus_addr); end
        dif.bus_ack   = 1'b1;
        dif.bus_rdata = 32'h0BAD_F00D;
        step();
        dif.bus_ack = 1'b0;
        n_cmp++; if ({dif.dValid, dif.dErr} !== 2'b10) begin n_bad++; $display("FAIL bb_done: got valid,err=%b want 10", {dif.dValid, dif.dErr}); end
        n_cmp++; if (dif.dReadData !== 32'h0BAD_F00D) begin n_bad++; $display("FAIL bb_data: got %h want 0badf00d", dif.dReadData); end
        step();
        dif.MemWrite = 1'b0;
        n_cmp++; if ({dif.dValid, dif.dBusy, dif.bus_req} !== 3'b000) begin n_bad++; $display("FAIL bb_no_queue: got valid,busy,req=%b want 000", {dif.dValid, dif.dBusy, dif.bus_req}); end
        step();
        n_cmp++; if ({dif.dBusy, dif.bus_req} !== 2'b00) begin n_bad++; $display("FAIL bb_idle: got busy,req=%b want 00", {dif.dBusy, dif.bus_req}); end
    endtask

    task automatic test_timeout();
        logic early;
        early = 1'b0;
        issue(1'b1, 1'b0, F_W, 32'h1001_000C, 32'd0);
`ifdef DMEM_TIMEOUT_EN
        for (int c = 1; c <= 16; c++) begin
            if (!dif.bus_req || dif.dValid) early = 1'b1;
            if (c < 16) step();
        end
        n_cmp++; if (early !== 1'b0) begin n_bad++; $display("FAIL tmo_busy_window: got early=%b want 0", early); end
        step();
        n_cmp++; if ({dif.dValid, dif.dErr, dif.bus_req} !== 3'b110) begin n_bad++; $display("FAIL tmo_done: got valid,err,req=%b want 110", {dif.dValid, dif.dErr, dif.bus_req}); end
        n_cmp++; if (dif.dReadData !== 32'h0BAD_F00D) begin n_bad++; $display("FAIL tmo_hold: got %h want 0badf00d", dif.dReadData); end
        step();
        n_cmp++; if ({dif.dValid, dif.dBusy, dif.bus_req} !== 3'b000) begin n_bad++; $display("FAIL tmo_idle: got valid,busy,req=%b want 000", {dif.dValid, dif.dBusy, dif.bus_req}); end
`else
        for (int c = 1; c <= 40; c++) begin
            if (!dif.bus_req || dif.dValid) early = 1'b1;
            step();
        end
        n_cmp++; if (early !== 1'b0) begin n_bad++; $display("FAIL wait_forever: got early=%b want 0", early); end
        dif.bus_ack   = 1'b1;
        dif.bus_rdata = 32'h1111_2222;
        step();
        dif.bus_ack = 1'b0;
        n_cmp++; if ({dif.dValid, dif.dErr, dif.bus_req} !== 3'b100) begin n_bad++; $display("FAIL late_ack_done: got valid,err,req=%b want 100", {dif.dValid, dif.dErr, dif.bus_req}); end
        n_cmp++; if (dif.dReadData !== 32'h1111_2222) begin n_bad++; $display("FAIL late_ack_data: got %h want 11112222", dif.dReadData); end
        step();
`endif
    endtask

    task automatic test_reset_mid_busy();
        issue(1'b1, 1'b0, F_W, 32'h1001_0010, 32'd0);
        n_cmp++; if (dif.bus_req !== 1'b1) begin n_bad++; $display("FAIL rmb_req_c1: got %b want 1", dif.bus_req); end
        step();
        rst_n = 1'b0;
        #1;
        n_cmp++; if (dif.bus_req !== 1'b0) begin n_bad++; $display("FAIL rmb_req_drop: got %b want 0", dif.bus_req); end
        n_cmp++; if (all_outs() !== 105'd0) begin n_bad++; $display("FAIL rmb_outs: got %h want 0", all_outs()); end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        n_cmp++; if (dut.state_q !== 2'd0) begin n_bad++; $display("FAIL rmb_state: got %0d want 0", dut.state_q); end
        n_cmp++; if (all_outs() !== 105'd0) begin n_bad++; $display("FAIL rmb_outs_after: got %h want 0", all_outs()); end
        issue(1'b1, 1'b0, F_BU, 32'h1001_0001, 32'd0);
        dif.bus_ack   = 1'b1;
        dif.bus_rdata = 32'h0000_C300;
        step();
        dif.bus_ack = 1'b0;
        n_cmp++; if (dif.dReadData !== 32'h0000_00C3) begin n_bad++; $display("FAIL rmb_recover: got %h want 000000c3", dif.dReadData); end
        step();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_lw();
        test_store();
        test_load_extend();
        test_reject();
        test_back_to_back();
        test_timeout();
        test_reset_mid_busy();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
